csr_access_unit: RTL and testbench

Pipeline-side initiator for the CSR register file. Accepts one decoded Zicsr instruction at a time (CSRRW/CSRRS/CSRRC and their immediate forms), sequences the `csr_en`/`csr_read`/`csr_write` strobes toward the CSR block, and performs the read-modify-write. It honours the CSR block's stall gating and its one-cycle registered read latency, then returns the old CSR value for write-back to `rd`. It sits between the execute stage and the CSR block.

---
 rtl/csr_access_unit_pkg.sv | 36 +++
 rtl/csr_access_unit_if.sv | 39 +++
 rtl/csr_access_unit_alu.sv | 23 ++
 rtl/csr_access_unit.sv | 136 +++++++++++++
 tb/tb_csr_access_unit.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/csr_access_unit_pkg.sv
// Shared types and constants for the CSR access path: sequencer states,
// Zicsr funct3 encodings and machine-mode CSR numbers.
package csr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC   = 3'd1,
    RD    = 3'd2,
    RWAIT = 3'd3,
    WR    = 3'd4,
    DONE  = 3'd5
  } csr_acc_state_e;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  // funct3 000 and 100 are not Zicsr operations
  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// Request/response bus from execute plus the strobe bus toward the CSR block.
interface csr_access_unit_if #(
  parameter int DW = 32,
  parameter int AW = 12
);
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_csr;
  logic [DW-1:0] req_rs1_data;
  logic [4:0]    req_zimm;
  logic          req_rs1_zero;
  logic          req_rd_zero;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_illegal;
  logic [AW-1:0] csr_addr;
  logic [DW-1:0] csr_write_data;
  logic          csr_en;
  logic          csr_read;
  logic          csr_write;
  logic [DW-1:0] csr_read_data;
  logic          Istall;
  logic          Dstall;

  modport slave (
    input  req_valid, req_funct3, req_csr, req_rs1_data, req_zimm,
           req_rs1_zero, req_rd_zero, csr_read_data, Istall, Dstall,
    output req_ready, rsp_valid, rsp_data, rsp_illegal,
           csr_addr, csr_write_data, csr_en, csr_read, csr_write
  );

  modport master (
    output req_valid, req_funct3, req_csr, req_rs1_data, req_zimm,
           req_rs1_zero, req_rd_zero, csr_read_data, Istall, Dstall,
    input  req_ready, rsp_valid, rsp_data, rsp_illegal,
           csr_addr, csr_write_data, csr_en, csr_read, csr_write
  );
endinterface

// File: rtl/csr_access_unit_alu.sv
// Read-modify-write datapath: new CSR value from the old value and operand.
module csr_alu
  import csr_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] old,
  input  logic [DW-1:0] operand,
  input  logic [1:0]    op,
  output logic [DW-1:0] result
);

  always_comb begin
    result = old;
    case (op)
      F3_RW[1:0]: result = operand;
      F3_RS[1:0]: result = old | operand;
      F3_RC[1:0]: result = old & ~operand;
      default:    result = old;
    endcase
  end

endmodule

// File: rtl/csr_access_unit.sv
// Sequences one Zicsr instruction at a time into CSR block strobes and
// returns the old CSR value.
//
//   state | meaning
//   IDLE  | ready for a request
//   ACC   | single-access swap (RW/RWI), read only when rd != x0
//   RD    | read phase of a set/clear
//   RWAIT | capture registered read data, compute new value
//   WR    | write phase of a set/clear
//   DONE  | one-cycle response
module csr_access_unit
  import csr_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 12
) (
  input logic         clk,
  input logic         rst,
  csr_access_unit_if.slave bus
);

  csr_acc_state_e state, state_nxt;

  logic [AW-1:0] addr_q;
  logic [1:0]    op_q;
  logic [DW-1:0] opnd_q;
  logic          rs1_zero_q;
  logic          rd_zero_q;
  logic [DW-1:0] old_q;
  logic [DW-1:0] wdata_q;
  logic          ill_q;

  logic          stall;
  logic          accept;
  logic [DW-1:0] req_opnd;
  logic [DW-1:0] alu_res;

  assign stall    = bus.Istall | bus.Dstall;
  assign accept   = (state == IDLE) && bus.req_valid;
  assign req_opnd = bus.req_funct3[2] ? {{(DW-5){1'b0}}, bus.req_zimm} : bus.req_rs1_data;

  csr_alu #(.DW(DW)) u_alu (
    .old     (bus.csr_read_data),
    .operand (opnd_q),
    .op      (op_q),
    .result  (alu_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      op_q       <= '0;
      opnd_q     <= '0;
      rs1_zero_q <= 1'b0;
      rd_zero_q  <= 1'b0;
      old_q      <= '0;
      wdata_q    <= '0;
      ill_q      <= 1'b0;
    end else begin
      if (accept) begin
        addr_q     <= bus.req_csr;
        op_q       <= bus.req_funct3[1:0];
        opnd_q     <= req_opnd;
        rs1_zero_q <= bus.req_rs1_zero;
        rd_zero_q  <= bus.req_rd_zero;
        old_q      <= '0;
        wdata_q    <= '0;
        ill_q      <= f3_illegal(bus.req_funct3);
      end
      // read data is registered in the CSR block, so it is valid here
      if (state == RWAIT) begin
        old_q   <= bus.csr_read_data;
        wdata_q <= alu_res;
      end
    end
  end

  always_comb begin
    state_nxt          = state;
    bus.req_ready      = 1'b0;
    bus.rsp_valid      = 1'b0;
    bus.rsp_data       = '0;
    bus.rsp_illegal    = 1'b0;
    bus.csr_addr       = addr_q;
    bus.csr_write_data = '0;
    bus.csr_en         = 1'b0;
    bus.csr_read       = 1'b0;
    bus.csr_write      = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        bus.csr_addr  = '0;
        if (bus.req_valid) begin
          if (f3_illegal(bus.req_funct3))               state_nxt = DONE;
          else if (bus.req_funct3[1:0] == F3_RW[1:0])   state_nxt = ACC;
          else                                          state_nxt = RD;
        end
      end
      ACC: begin
        bus.csr_en         = 1'b1;
        bus.csr_write      = 1'b1;
        bus.csr_write_data = opnd_q;
        bus.csr_read       = !rd_zero_q;
        if (!stall) state_nxt = rd_zero_q ? DONE : RWAIT;
      end
      RD: begin
        bus.csr_en   = 1'b1;
        bus.csr_read = 1'b1;
        if (!stall) state_nxt = RWAIT;
      end
      RWAIT: begin
        if (op_q == F3_RW[1:0] || rs1_zero_q) state_nxt = DONE;
        else                                  state_nxt = WR;
      end
      WR: begin
        bus.csr_en         = 1'b1;
        bus.csr_write      = 1'b1;
        bus.csr_write_data = wdata_q;
        if (!stall) state_nxt = DONE;
      end
      DONE: begin
        bus.rsp_valid   = 1'b1;
        bus.rsp_data    = old_q;
        bus.rsp_illegal = ill_q;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed vector bench for csr_access_unit with a small CSR block model.
module tb_csr_access_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csr_access_unit_if #(.DW(32), .AW(12)) bus ();

  csr_access_unit #(.DW(32), .AW(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // CSR block model: registered read, write and read ignored while stalled
  logic [31:0] mem [0:4095];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [31:0] pl_val = '0;
  int          n_rd_tot = 0;
  int          n_wr_tot = 0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_val;
    else if (bus.csr_en && !(bus.Istall || bus.Dstall)) begin
      if (bus.csr_read) begin
        bus.csr_read_data <= mem[bus.csr_addr];
        n_rd_tot <= n_rd_tot + 1;
      end
      if (bus.csr_write) begin
        mem[bus.csr_addr] <= bus.csr_write_data;
        n_wr_tot <= n_wr_tot + 1;
      end
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [11:0] csr;
    logic [31:0] rs1;
    logic [4:0]  zimm;
    logic        rs1_zero;
    logic        rd_zero;
    logic [31:0] init;
    logic [15:0] stl_i;
    logic [15:0] stl_d;
    int          lat;
    logic [31:0] rsp;
    logic        ill;
    logic [31:0] fin;
    int          n_wr;
    int          n_rd;
  } vec_t;

  vec_t vecs [16];

  task automatic run_vec(input vec_t v);
    int          lat;
    logic [31:0] r_data;
    logic        r_ill;
    int          rd0, wr0, ready_bad, addr_bad, wd_bad;
    lat = 0; r_data = '0; r_ill = 1'b0;
    ready_bad = 0; addr_bad = 0; wd_bad = 0;
    pl_en = 1'b1; pl_addr = v.csr; pl_val = v.init;
    @(posedge clk); @(negedge clk);
    pl_en = 1'b0;
    rd0 = n_rd_tot; wr0 = n_wr_tot;
    bus.req_valid    = 1'b1;
    bus.req_funct3   = v.f3;
    bus.req_csr      = v.csr;
    bus.req_rs1_data = v.rs1;
    bus.req_zimm     = v.zimm;
    bus.req_rs1_zero = v.rs1_zero;
    bus.req_rd_zero  = v.rd_zero;
    bus.Istall       = v.stl_i[0];
    bus.Dstall       = v.stl_d[0];
    for (int cyc = 1; cyc <= 30 && lat == 0; cyc++) begin
      @(posedge clk); @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.req_ready !== 1'b0) ready_bad++;
      if (bus.csr_addr !== v.csr) addr_bad++;
      if (bus.csr_write === 1'b1 && bus.csr_write_data !== v.fin) wd_bad++;
      if (bus.rsp_valid === 1'b1) begin
        lat    = cyc;
        r_data = bus.rsp_data;
        r_ill  = bus.rsp_illegal;
      end
      bus.Istall = (cyc < 16) ? v.stl_i[cyc] : 1'b0;
      bus.Dstall = (cyc < 16) ? v.stl_d[cyc] : 1'b0;
    end
    bus.Istall = 1'b0; bus.Dstall = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({v.name, " after_done valid/ready"}, {30'd0, bus.rsp_valid, bus.req_ready}, 32'd1);
    chk({v.name, " latency"},    lat, v.lat);
    chk({v.name, " rsp_data"},   r_data, v.rsp);
    chk({v.name, " rsp_illegal"}, {31'd0, r_ill}, {31'd0, v.ill});
    chk({v.name, " csr_final"},  mem[v.csr], v.fin);
    chk({v.name, " writes"},     n_wr_tot - wr0, v.n_wr);
    chk({v.name, " reads"},      n_rd_tot - rd0, v.n_rd);
    chk({v.name, " ready_busy"}, ready_bad, 0);
    chk({v.name, " addr_busy"},  addr_bad, 0);
    chk({v.name, " wdata"},      wd_bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rsp_seen;
    rst = 1'b1;
    bus.req_valid = 0; bus.req_funct3 = 0; bus.req_csr = 0; bus.req_rs1_data = 0;
    bus.req_zimm = 0; bus.req_rs1_zero = 0; bus.req_rd_zero = 0;
    bus.Istall = 0; bus.Dstall = 0; bus.csr_read_data = 0;

    //          name        f3      csr      rs1           zimm   r1z  rdz  init          stl_i     stl_d     lat rsp           ill fin           wr rd
    vecs[0]  = '{"csrrs",    3'b010, 12'h300, 32'h0000_0080, 5'h00, 1'b0, 1'b0, 32'h0000_0008, 16'h0000, 16'h0000, 4, 32'h0000_0008, 1'b0, 32'h0000_0088, 1, 1};
    vecs[1]  = '{"csrrci",   3'b111, 12'h300, 32'h0000_0000, 5'h08, 1'b0, 1'b0, 32'h0000_0088, 16'h0000, 16'h0000, 4, 32'h0000_0088, 1'b0, 32'h0000_0080, 1, 1};
    vecs[2]  = '{"rw_rd0",   3'b001, 12'h305, 32'h0000_1000, 5'h00, 1'b0, 1'b1, 32'h0000_DEAD, 16'h0000, 16'h0000, 2, 32'h0000_0000, 1'b0, 32'h0000_1000, 1, 0};
    vecs[3]  = '{"rw_read",  3'b001, 12'h341, 32'h1234_5678, 5'h00, 1'b0, 1'b0, 32'h8000_0004, 16'h0000, 16'h0000, 3, 32'h8000_0004, 1'b0, 32'h1234_5678, 1, 1};
    vecs[4]  = '{"rs_x0",    3'b010, 12'h344, 32'h0000_0000, 5'h00, 1'b1, 1'b0, 32'h0000_0888, 16'h0000, 16'h0000, 3, 32'h0000_0888, 1'b0, 32'h0000_0888, 0, 1};
    vecs[5]  = '{"csrrc",    3'b011, 12'hB00, 32'h0000_FF00, 5'h00, 1'b0, 1'b0, 32'hFFFF_FFFF, 16'h0000, 16'h0000, 4, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_00FF, 1, 1};
    vecs[6]  = '{"csrrwi",   3'b101, 12'h304, 32'hFFFF_FFFF, 5'h1F, 1'b0, 1'b0, 32'hABCD_0000, 16'h0000, 16'h0000, 3, 32'hABCD_0000, 1'b0, 32'h0000_001F, 1, 1};
    vecs[7]  = '{"csrrsi",   3'b110, 12'hB02, 32'hFFFF_FFFF, 5'h15, 1'b0, 1'b0, 32'hFFFF_FFE0, 16'h0000, 16'h0000, 4, 32'hFFFF_FFE0, 1'b0, 32'hFFFF_FFF5, 1, 1};
    vecs[8]  = '{"ill_100",  3'b100, 12'h300, 32'h0000_0001, 5'h01, 1'b0, 1'b0, 32'h0000_0005, 16'h0000, 16'h0000, 1, 32'h0000_0000, 1'b1, 32'h0000_0005, 0, 0};
    vecs[9]  = '{"ill_000",  3'b000, 12'h305, 32'h0000_0001, 5'h00, 1'b0, 1'b0, 32'h0000_0007, 16'h0000, 16'h0000, 1, 32'h0000_0000, 1'b1, 32'h0000_0007, 0, 0};
    vecs[10] = '{"rsi_z0",   3'b110, 12'hB80, 32'h0000_0000, 5'h00, 1'b1, 1'b0, 32'h0000_0042, 16'h0000, 16'h0000, 3, 32'h0000_0042, 1'b0, 32'h0000_0042, 0, 1};
    vecs[11] = '{"rci_rd0",  3'b111, 12'hB82, 32'h0000_0000, 5'h10, 1'b0, 1'b1, 32'h0000_00F0, 16'h0000, 16'h0000, 4, 32'h0000_00F0, 1'b0, 32'h0000_00E0, 1, 1};
    vecs[12] = '{"rs_x0_ds", 3'b010, 12'h341, 32'h0000_0000, 5'h00, 1'b1, 1'b0, 32'h8000_0100, 16'h0000, 16'h000E, 6, 32'h8000_0100, 1'b0, 32'h8000_0100, 0, 1};
    vecs[13] = '{"rs_wr_is", 3'b010, 12'h300, 32'h0000_0002, 5'h00, 1'b0, 1'b0, 32'h0000_0001, 16'h0018, 16'h0000, 6, 32'h0000_0001, 1'b0, 32'h0000_0003, 1, 1};
    vecs[14] = '{"rc_nostl", 3'b011, 12'hB80, 32'h0000_000F, 5'h00, 1'b0, 1'b0, 32'h0000_00FF, 16'h0000, 16'h0014, 4, 32'h0000_00FF, 1'b0, 32'h0000_00F0, 1, 1};
    vecs[15] = '{"rw_acc_s", 3'b001, 12'hB00, 32'h0000_0055, 5'h00, 1'b0, 1'b0, 32'h0000_0077, 16'h0002, 16'h0000, 4, 32'h0000_0077, 1'b0, 32'h0000_0055, 1, 1};

    @(negedge clk); @(negedge clk);
    chk("reset req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("reset strobes", {27'd0, bus.csr_en, bus.csr_read, bus.csr_write, bus.rsp_valid, bus.rsp_illegal}, 32'd0);
    chk("reset csr_addr", {20'd0, bus.csr_addr}, 32'd0);
    chk("reset rsp_data", bus.rsp_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) run_vec(vecs[i]);

    // reset asserted while the unit is driving the write phase
    pl_en = 1'b1; pl_addr = 12'h300; pl_val = 32'h0000_0010;
    @(posedge clk); @(negedge clk);
    pl_en = 1'b0;
    bus.req_valid = 1'b1; bus.req_funct3 = 3'b010; bus.req_csr = 12'h300;
    bus.req_rs1_data = 32'h0000_0001; bus.req_zimm = 0;
    bus.req_rs1_zero = 1'b0; bus.req_rd_zero = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); @(negedge clk);
      bus.req_valid = 1'b0;
    end
    chk("rst_wr in WR", {30'd0, bus.csr_en, bus.csr_write}, 32'd3);
    rst = 1'b1;
    #1;
    chk("rst_wr outputs", {27'd0, bus.csr_en, bus.csr_read, bus.csr_write, bus.rsp_valid, bus.req_ready}, 32'd1);
    chk("rst_wr csr_addr", {20'd0, bus.csr_addr}, 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    rsp_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); @(negedge clk);
      if (bus.rsp_valid === 1'b1) rsp_seen++;
    end
    chk("rst_wr no rsp", rsp_seen, 0);
    chk("rst_wr no write", mem[12'h300], 32'h0000_0010);
    chk("rst_wr ready", {31'd0, bus.req_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
